uart_tx_scheduler: RTL and testbench

//  Shares one uart_transmitter between NUM_REQ independent byte sources. Picks a source round-robin,

---
 rtl/uart_pkg.sv | 17 +
 rtl/uart_rr_arbiter.sv | 34 +++
 rtl/uart_tx_scheduler.sv | 136 +++++++++++++
 tb/tb_uart_tx_scheduler.sv | 383 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared types and constants for the UART transmit path.
// Holds the scheduler state encoding and the default byte width.
package uart_pkg;

    // Default byte width; matches the uart_transmitter data width.
    localparam int UART_DATA_SIZE = 8;

    // Scheduler states. GAP is only reachable when the inter-frame gap
    // feature is compiled in (UART_TX_SCHED_GAP_EN).
    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        START     = 2'd1,
        WAIT_DONE = 2'd2,
        GAP       = 2'd3
    } sched_state_e;

endpackage

// File: rtl/uart_rr_arbiter.sv
// Round-robin arbiter, purely combinational.
// Grants the first asserted request strictly after i_pointer, wrapping from
// NUM_REQ-1 back to 0. The pointer register itself lives in the caller.
module uart_rr_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] i_req,
    input  logic [ID_W-1:0]    i_pointer,
    input  logic               i_enable,
    output logic [NUM_REQ-1:0] o_grant,
    output logic [ID_W-1:0]    o_grant_idx
);

    logic w_found;
    int   w_idx;

    // Scan requesters starting one past the pointer; first hit wins.
    always_comb begin
        o_grant     = '0;
        o_grant_idx = '0;
        w_found     = 1'b0;
        w_idx       = 0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            w_idx = (int'(i_pointer) + k) % NUM_REQ;
            if (i_enable && !w_found && i_req[w_idx]) begin
                w_found        = 1'b1;
                o_grant[w_idx] = 1'b1;
                o_grant_idx    = ID_W'(w_idx);
            end
        end
    end

endmodule

// File: rtl/uart_tx_scheduler.sv
// Shares one uart_transmitter between NUM_REQ byte sources.
// Picks a source round-robin, latches its byte, pulses tx_start_n low for one
// cycle and waits for tx_done before accepting the next byte.
// Handshake: a byte from requester i is taken in the cycle where
// req_valid[i] & req_ready[i]; req_ready is one-hot and only ever asserted in
// IDLE (and never while reset_n is low), and a requester holds
// req_valid/req_data stable until taken.
// Optional feature: define UART_TX_SCHED_GAP_EN to insert gap_cycles idle
// cycles (GAP state) after each frame; otherwise gap_cycles is ignored.
module uart_tx_scheduler
    import uart_pkg::*;
#(
    parameter int NUM_REQ   = 4,
    parameter int DATA_SIZE = UART_DATA_SIZE,
    parameter int GAP_W     = 4,
    parameter int ID_W      = $clog2(NUM_REQ)
) (
    input  logic                         clk,
    input  logic                         reset_n,
    input  logic [NUM_REQ-1:0]           req_valid,
    input  logic [NUM_REQ*DATA_SIZE-1:0] req_data,
    output logic [NUM_REQ-1:0]           req_ready,
    input  logic [GAP_W-1:0]             gap_cycles,
    output logic                         tx_start_n,
    output logic [DATA_SIZE-1:0]         tx_data,
    input  logic                         tx_done,
    output logic                         busy,
    output logic [ID_W-1:0]              grant_id
);

    sched_state_e          r_state;
    sched_state_e          w_state_nxt;
    logic [DATA_SIZE-1:0]  r_tx_data;
    logic [ID_W-1:0]       r_grant_id;
    logic [ID_W-1:0]       r_ptr;

    logic [NUM_REQ-1:0]    w_grant;
    logic [ID_W-1:0]       w_grant_idx;
    logic                  w_arb_en;
    logic                  w_accept;
    logic [DATA_SIZE-1:0]  w_sel_data;

    // Arbitration only in IDLE; gating with reset_n keeps req_ready low while
    // reset is held even though the state register already reads IDLE.
    assign w_arb_en   = (r_state == IDLE) && reset_n;
    assign w_accept   = |w_grant;
    assign w_sel_data = req_data[int'(w_grant_idx)*DATA_SIZE +: DATA_SIZE];

    uart_rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .ID_W    (ID_W)
    ) u_arb (
        .i_req       (req_valid),
        .i_pointer   (r_ptr),
        .i_enable    (w_arb_en),
        .o_grant     (w_grant),
        .o_grant_idx (w_grant_idx)
    );

`ifdef UART_TX_SCHED_GAP_EN
    logic [GAP_W-1:0] r_gap_cnt;

    // Gap down-counter: loaded from gap_cycles at tx_done, counts in GAP.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_gap_cnt <= '0;
        end else if (r_state == WAIT_DONE && tx_done) begin
            r_gap_cnt <= gap_cycles;
        end else if (r_state == GAP && r_gap_cnt != '0) begin
            r_gap_cnt <= r_gap_cnt - 1'b1;
        end
    end
`else
    logic w_gap_unused;
    assign w_gap_unused = ^gap_cycles;
`endif

    // State, latched byte, grant index and round-robin pointer.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state    <= IDLE;
            r_tx_data  <= '0;
            r_grant_id <= '0;
            r_ptr      <= ID_W'(NUM_REQ - 1);
        end else begin
            r_state <= w_state_nxt;
            if (w_accept) begin
                r_tx_data  <= w_sel_data;
                r_grant_id <= w_grant_idx;
                r_ptr      <= w_grant_idx;
            end
        end
    end

    // Next-state logic; tx_done outside WAIT_DONE is deliberately ignored.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE: begin
                if (w_accept) w_state_nxt = START;
            end
            START: begin
                w_state_nxt = WAIT_DONE;
            end
            WAIT_DONE: begin
                if (tx_done) begin
`ifdef UART_TX_SCHED_GAP_EN
                    w_state_nxt = (gap_cycles != '0) ? GAP : IDLE;
`else
                    w_state_nxt = IDLE;
`endif
                end
            end
            GAP: begin
`ifdef UART_TX_SCHED_GAP_EN
                if (r_gap_cnt <= GAP_W'(1)) w_state_nxt = IDLE;
`else
                w_state_nxt = IDLE;
`endif
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    // Outputs decoded from the state register.
    always_comb begin
        tx_start_n = 1'b1;
        busy       = 1'b0;
        req_ready  = w_grant;
        tx_data    = r_tx_data;
        grant_id   = r_grant_id;
        if (r_state == START) tx_start_n = 1'b0;
        if (r_state != IDLE)  busy       = 1'b1;
    end

endmodule

// File: tb/tb_uart_tx_scheduler.sv
// Bench for uart_tx_scheduler: randomized requesters, a transmitter stand-in
// that answers tx_start_n with tx_done 11 cycles later, and a scoreboard.
module tb_uart_tx_scheduler;

  localparam int N  = 4;
  localparam int DW = 8;
  localparam int GW = 4;
  localparam int IW = 2;

  logic            clk = 1'b0;
  logic            reset_n;
  logic [N-1:0]    req_valid;
  logic [N*DW-1:0] req_data;
  logic [N-1:0]    req_ready;
  logic [GW-1:0]   gap_cycles;
  logic            tx_start_n;
  logic [DW-1:0]   tx_data;
  logic            tx_done;
  logic            busy;
  logic [IW-1:0]   grant_id;

  uart_tx_scheduler #(.NUM_REQ(N), .DATA_SIZE(DW), .GAP_W(GW), .ID_W(IW)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .req_valid  (req_valid),
    .req_data   (req_data),
    .req_ready  (req_ready),
    .gap_cycles (gap_cycles),
    .tx_start_n (tx_start_n),
    .tx_data    (tx_data),
    .tx_done    (tx_done),
    .busy       (busy),
    .grant_id   (grant_id)
  );

  // ---------------- clock / reset / cycle count ----------------
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- bookkeeping ----------------
  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s @cyc %0d: got %0h expected %0h", nm, cyc, act, exp);
    end
  endtask

  task automatic fail_now(input string nm);
    n_checks++;
    n_fail++;
    $display("FAIL %s @cyc %0d: condition not reached", nm, cyc);
  endtask

  // ---------------- reference model state ----------------
  // A frame is: accepted at cycle a, start pulse at a+1, then the frame
  // ends at the first tx_done seen after the start cycle; the scheduler is
  // free again gap cycles after the cycle following tx_done.
  bit            m_busy      = 1'b0;
  int            m_ptr       = N - 1;
  int            m_start_cyc = -100;
  bit            m_done_seen = 1'b0;
  int            m_idle_at   = 0;
  logic [DW-1:0] m_cur_data  = '0;

  logic [DW-1:0] exp_q[$];
  logic [IW-1:0] gid_q[$];
  int            log_gid[$];
  int            log_data[$];
  int            acc_log[$];
  int            start_log[$];

  logic [N-1:0]  acc_mask   = '0;
  int            seen_start = -100;

  function automatic int gap_model();
`ifdef UART_TX_SCHED_GAP_EN
    return int'(gap_cycles);
`else
    return 0;
`endif
  endfunction

  // ---------------- monitor / scoreboard ----------------
  always @(negedge clk) begin : mon
    logic [N-1:0]  e_rdy;
    int            g;
    logic [DW-1:0] d;
    logic [IW-1:0] gi;
    if (!reset_n) begin
      m_busy = 1'b0;
      m_ptr  = N - 1;
      exp_q.delete();
      gid_q.delete();
      acc_mask   = '0;
      seen_start = -100;
    end else begin
      if (m_busy && m_done_seen && cyc >= m_idle_at) m_busy = 1'b0;
      e_rdy = '0;
      g = -1;
      if (!m_busy) begin
        for (int k = 1; k <= N; k++) begin
          if (req_valid[(m_ptr + k) % N]) begin
            g = (m_ptr + k) % N;
            break;
          end
        end
        if (g >= 0) e_rdy[g] = 1'b1;
      end
      chk("req_ready", 32'(req_ready), 32'(e_rdy));
      chk("busy", 32'(busy), 32'(m_busy));
      chk("tx_start_n", 32'(tx_start_n), 32'(!(m_busy && cyc == m_start_cyc)));
      if (tx_start_n === 1'b0) begin
        seen_start = cyc;
        start_log.push_back(cyc);
        if (exp_q.size() == 0) begin
          fail_now("start_without_grant");
        end else begin
          d  = exp_q.pop_front();
          gi = gid_q.pop_front();
          chk("tx_data", 32'(tx_data), 32'(d));
          chk("grant_id", 32'(grant_id), 32'(gi));
          log_gid.push_back(int'(grant_id));
          log_data.push_back(int'(tx_data));
        end
      end
      if (m_busy && cyc > m_start_cyc && !m_done_seen) begin
        chk("tx_data_hold", 32'(tx_data), 32'(m_cur_data));
        if (tx_done) begin
          m_done_seen = 1'b1;
          m_idle_at   = cyc + 1 + gap_model();
        end
      end
      if (g >= 0) begin
        exp_q.push_back(req_data[g*DW +: DW]);
        gid_q.push_back(IW'(g));
        m_cur_data  = req_data[g*DW +: DW];
        m_ptr       = g;
        m_busy      = 1'b1;
        m_start_cyc = cyc + 1;
        m_done_seen = 1'b0;
        acc_log.push_back(cyc);
      end
      acc_mask = req_ready & req_valid;
    end
  end

  // ---------------- driver ----------------
  logic [N-1:0]  v = '0;
  logic [DW-1:0] dd[N];
  int            mode        = 0;   // 0: directed, 1: random
  bit            drop_on_acc = 1'b0;
  int            done_at     = -100;

  task automatic drive();
    req_valid = v;
    for (int i = 0; i < N; i++) req_data[i*DW +: DW] = dd[i];
  endtask

  task automatic step(input bit sp = 1'b0);
    bit spur;
    @(posedge clk);
    #1;
    spur = sp;
    if (seen_start == cyc - 1) done_at = cyc + 10;
    for (int i = 0; i < N; i++) begin
      if (acc_mask[i]) begin
        if (mode == 1) begin
          if ($urandom_range(0, 1) == 1) dd[i] = 8'($urandom_range(0, 255));
          else v[i] = 1'b0;
        end else if (drop_on_acc) begin
          v[i] = 1'b0;
        end
      end else if (mode == 1) begin
        if (!v[i]) begin
          if ($urandom_range(0, 3) == 0) begin
            v[i]  = 1'b1;
            dd[i] = 8'($urandom_range(0, 255));
          end
        end else if ($urandom_range(0, 15) == 0) begin
          v[i] = 1'b0;
        end
      end
    end
    acc_mask = '0;
    if (mode == 1) begin
      if ($urandom_range(0, 63) == 0) gap_cycles = 4'($urandom_range(0, 3));
      if (!m_busy && $urandom_range(0, 31) == 0) spur = 1'b1;
    end
    tx_done = (cyc == done_at) || spur;
    drive();
  endtask

  task automatic wait_acc(input int target, input string nm);
    for (int t = 0; t < 400; t++) begin
      if (acc_log.size() >= target) return;
      step();
    end
    fail_now(nm);
  endtask

  task automatic wait_quiet(input string nm);
    for (int t = 0; t < 400; t++) begin
      if (!m_busy && v == '0) begin
        step();
        return;
      end
      step();
    end
    fail_now(nm);
  endtask

  task automatic do_reset();
    #2;
    reset_n = 1'b0;
    done_at = -100;
    #1;
    chk("rst_tx_start_n", 32'(tx_start_n), 32'd1);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_req_ready", 32'(req_ready), 32'd0);
    chk("rst_grant_id", 32'(grant_id), 32'd0);
    chk("rst_tx_data", 32'(tx_data), 32'd0);
    step();
    step();
    reset_n = 1'b1;
  endtask

  // Timing of two back-to-back frames from one held requester.
  task automatic frame_pair(input int req, input logic [DW-1:0] val, input int exp_dist, input string nm);
    int base;
    drop_on_acc = 1'b0;
    v = '0;
    v[req]  = 1'b1;
    dd[req] = val;
    drive();
    base = acc_log.size();
    wait_acc(base + 2, {nm, "_timeout"});
    v = '0;
    drive();
    if (acc_log.size() >= base + 2)
      chk(nm, 32'(acc_log[base+1] - acc_log[base]), 32'(exp_dist));
    wait_quiet({nm, "_quiet"});
  endtask

  // ---------------- main sequence ----------------
  initial begin : main
    int base;
    int sbase;
    int exp_ord[4];
    int exp_dat[4];
    reset_n    = 1'b0;
    gap_cycles = '0;
    tx_done    = 1'b0;
    for (int i = 0; i < N; i++) dd[i] = '0;
    v = 4'b1111;
    drive();
    #1;
    chk("init_tx_start_n", 32'(tx_start_n), 32'd1);
    chk("init_busy", 32'(busy), 32'd0);
    chk("init_req_ready", 32'(req_ready), 32'd0);
    chk("init_tx_data", 32'(tx_data), 32'd0);
    chk("init_grant_id", 32'(grant_id), 32'd0);
    v = '0;
    drive();
    step();
    step();
    reset_n = 1'b1;
    step();

    // 1: single requester, A5; start one cycle after accept, next accept 13 later.
    base  = acc_log.size();
    sbase = start_log.size();
    frame_pair(0, 8'hA5, 13, "single_accept_spacing");
    if (start_log.size() > sbase && acc_log.size() > base)
      chk("single_start_latency", 32'(start_log[sbase] - acc_log[base]), 32'd1);
    if (log_data.size() > 0) chk("single_data", 32'(log_data[log_data.size()-1]), 32'hA5);

    // 2: contention from a fresh reset, 0101 held -> 0,2,0,2.
    do_reset();
    drop_on_acc = 1'b0;
    v = 4'b0101;
    dd[0] = 8'h11;
    dd[2] = 8'h33;
    drive();
    base = log_gid.size();
    for (int t = 0; t < 400 && log_gid.size() < base + 4; t++) step();
    v = '0;
    drive();
    exp_ord = '{0, 2, 0, 2};
    exp_dat = '{8'h11, 8'h33, 8'h11, 8'h33};
    if (log_gid.size() < base + 4) fail_now("contention_timeout");
    else for (int i = 0; i < 4; i++) begin
      chk("contention_order", 32'(log_gid[base+i]), 32'(exp_ord[i]));
      chk("contention_data", 32'(log_data[base+i]), 32'(exp_dat[i]));
    end
    wait_quiet("contention_quiet");

    // 3: wrap: grant 3 to park the pointer, then 1001 -> 0 then 3.
    drop_on_acc = 1'b1;
    v = 4'b1000;
    dd[3] = 8'h3C;
    drive();
    wait_quiet("wrap_prep");
    v = 4'b1001;
    dd[0] = 8'hC0;
    drive();
    base = log_gid.size();
    for (int t = 0; t < 400 && log_gid.size() < base + 2; t++) step();
    if (log_gid.size() < base + 2) fail_now("wrap_timeout");
    else begin
      chk("wrap_first", 32'(log_gid[base]), 32'd0);
      chk("wrap_second", 32'(log_gid[base+1]), 32'd3);
    end
    wait_quiet("wrap_quiet");

    // 4: reset at cycle 6 of a frame; afterwards requester 0 wins first.
    drop_on_acc = 1'b1;
    v = 4'b0100;
    dd[2] = 8'h5A;
    drive();
    repeat (6) step();
    v = 4'b1111;
    drive();
    do_reset();
    drop_on_acc = 1'b1;
    for (int i = 0; i < N; i++) dd[i] = 8'(8'h70 + i);
    base = log_gid.size();
    for (int t = 0; t < 400 && log_gid.size() < base + 1; t++) step();
    if (log_gid.size() < base + 1) fail_now("post_reset_timeout");
    else chk("post_reset_first_grant", 32'(log_gid[base]), 32'd0);
    for (int t = 0; t < 400 && v != '0; t++) step();
    wait_quiet("post_reset_quiet");

    // 5: inter-frame gap.
    gap_cycles = 4'd3;
`ifdef UART_TX_SCHED_GAP_EN
    frame_pair(1, 8'h42, 16, "gap3_accept_spacing");
`else
    frame_pair(1, 8'h42, 13, "gap_ignored_spacing");
`endif
    gap_cycles = 4'd0;
    frame_pair(1, 8'h24, 13, "gap0_accept_spacing");

    // 6: spurious tx_done in IDLE and in START.
    step(1'b1);
    step(1'b1);
    step();
    chk("spur_idle_busy", 32'(busy), 32'd0);
    sbase = start_log.size();
    drop_on_acc = 1'b1;
    v = 4'b0010;
    dd[1] = 8'hE7;
    drive();
    step(1'b1);
    wait_quiet("spur_quiet");
    chk("spur_single_start", 32'(start_log.size() - sbase), 32'd1);

    // Random traffic.
    mode = 1;
    repeat (3000) step();
    mode = 0;
    v = '0;
    drive();
    wait_quiet("random_drain");
    repeat (3) step();
    chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
